// File: rtl/midi_out.sv
// midi_out: MIDI 8-N-1 serial transmitter for 1..3 byte messages at CLKS_PER_BIT clocks per bit.
// Bytes of one message go out back-to-back, LSB first; serial, ready and tx_done are registered.
module midi_out #(
   parameter int CLKS_PER_BIT = 1600
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] msg_bytes,
   input  logic [1:0]  msg_len,
   input  logic        send,
   output logic        ready,
   output logic        serial,
   output logic        tx_done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [1:0]       byte_idx;
   logic [1:0]       len_q;
   logic [23:0]      data_q;
   logic [7:0]       cur_byte;
   logic             accept;
   logic             bit_end;

   assign accept  = send && ready;
   assign bit_end = (bit_cnt == CNT_LAST);

   always_comb begin
      case (byte_idx)
         2'd1:    cur_byte = data_q[15:8];
         2'd2:    cur_byte = data_q[23:16];
         default: cur_byte = data_q[7:0];
      endcase
   end

   // Message payload is plain data: captured on acceptance, never reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= msg_bytes;
         len_q  <= msg_len;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         serial   <= 1'b1;
         ready    <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (state != IDLE) begin
            bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               // Empty messages are accepted but leave the transmitter idle.
               if (accept && (msg_len != 2'd0)) begin
                  state    <= START;
                  serial   <= 1'b0;
                  ready    <= 1'b0;
                  byte_idx <= '0;
                  bit_cnt  <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  serial  <= cur_byte[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     state  <= STOP;
                     serial <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     serial  <= cur_byte[bit_idx + 3'd1];
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (byte_idx == len_q - 2'd1) begin
                     state   <= IDLE;
                     ready   <= 1'b1;
                     tx_done <= 1'b1;
                  end else begin
                     // Next start bit follows the stop bit with no idle gap.
                     byte_idx <= byte_idx + 2'd1;
                     state    <= START;
                     serial   <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_midi_out.sv
// tb_midi_out: randomized and directed checks of midi_out against a cycle-level message model.
module tb_midi_out;
   localparam int C = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] msg_bytes = '0;
   logic [1:0]  msg_len = '0;
   logic        send = 1'b0;
   logic        ready, serial, tx_done;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;
   int cyc = 0;

   midi_out #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .msg_bytes(msg_bytes), .msg_len(msg_len),
      .send(send), .ready(ready), .serial(serial), .tx_done(tx_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Model: a message is a timeline of 10*N bit slots, each C cycles long, counted from acceptance.
   bit       m_busy = 0;
   bit       m_done = 0;
   int       m_cnt = 0;
   int       m_len = 0;
   logic [7:0] m_bytes [3];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0;
         m_done = 0;
         m_cnt  = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == 10 * m_len * C) begin
               m_busy = 0;
               m_done = 1;
            end
         end else if (send && msg_len != 2'd0) begin
            m_busy = 1;
            m_cnt  = 0;
            m_len  = int'(msg_len);
            m_bytes[0] = msg_bytes[7:0];
            m_bytes[1] = msg_bytes[15:8];
            m_bytes[2] = msg_bytes[23:16];
         end
      end
   end

   function automatic logic exp_serial();
      int slot, j, k;
      if (!m_busy) return 1'b1;
      slot = m_cnt / C;
      j = slot / 10;
      k = slot % 10;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_bytes[j][k-1];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({serial, ready, tx_done} !== {exp_serial(), ~m_busy, m_done}) begin
            errors++;
            $display("FAIL model cycle=%0d serial/ready/tx_done got=%b%b%b expected=%b%b%b",
                     cyc, serial, ready, tx_done, exp_serial(), ~m_busy, m_done);
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic wait_ready(input int budget);
      for (int i = 0; i < budget && ready !== 1'b1; i++) @(negedge clk);
      check("wait_ready", int'(ready), 1);
   endtask

   // Issue one request at a negedge (ready is high), then watch 10*n*C+4 cycles after acceptance.
   task automatic send_observe(input logic [23:0] d, input logic [1:0] n,
                               output logic [29:0] bits, output int low,
                               output int dcount, output int dat);
      @(negedge clk);
      msg_bytes = d;
      msg_len = n;
      send = 1'b1;
      @(posedge clk);
      #1 send = 1'b0;
      low = 0; dcount = 0; dat = -1; bits = '1;
      for (int i = 0; i < 10 * int'(n) * C + 4; i++) begin
         @(negedge clk);
         if (!ready) low++;
         if (tx_done) begin dcount++; dat = i; end
         if ((i % C) == C / 2 && (i / C) < 30) bits[i / C] = serial;
      end
   endtask

   task automatic check_frames(input string name, input logic [29:0] bits, input int n,
                               input logic [23:0] exp);
      logic [23:0] e;
      e = exp;
      for (int j = 0; j < n; j++)
         check(name, int'(bits[10*j +: 10]), int'({1'b1, e[8*j +: 8], 1'b0}));
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [29:0] bits;
      logic        s [0:400];
      int low, dcount, dat, acc2, hi_run, nlow, slow;
      bit seen_hi;

      #1 rst = 1'b1;
      #1 chk_en = 1;
      repeat (3) @(negedge clk);
      check("reset_serial", int'(serial), 1);
      check("reset_ready", int'(ready), 1);
      check("reset_tx_done", int'(tx_done), 0);
      rst = 1'b0;

      // Idle with send low and noisy data inputs
      nlow = 0; slow = 0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         msg_bytes = 24'($urandom);
         msg_len = 2'($urandom);
         if (!ready) nlow++;
         if (!serial) slow++;
      end
      check("idle_ready_low_cycles", nlow, 0);
      check("idle_serial_low_cycles", slow, 0);

      // Note On, three bytes
      send_observe(24'h40_3C_90, 2'd3, bits, low, dcount, dat);
      check_frames("noteon_frame", bits, 3, 24'h40_3C_90);
      check("noteon_ready_low", low, 480);
      check("noteon_done_pulses", dcount, 1);
      check("noteon_done_at", dat, 480);

      // Two-byte message with send held high: second acceptance one idle cycle later
      @(negedge clk);
      msg_bytes = 24'h00_05_C0;
      msg_len = 2'd2;
      send = 1'b1;
      @(posedge clk);
      acc2 = -1; seen_hi = 0;
      for (int i = 0; i <= 400; i++) begin
         @(negedge clk);
         s[i] = serial;
         if (ready) seen_hi = 1;
         else if (seen_hi && acc2 < 0) begin acc2 = i; send = 1'b0; end
      end
      send = 1'b0;
      hi_run = 0;
      for (int i = 320; i >= 0 && s[i] == 1'b1; i--) hi_run++;
      check("b2b_second_accept", acc2, 321);
      check("b2b_high_run", hi_run, C + 1);
      check("b2b_second_start_low", int'(s[321]), 0);
      wait_ready(400);

      // Empty messages
      nlow = 0; slow = 0;
      @(negedge clk);
      msg_len = 2'd0;
      send = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         msg_bytes = 24'($urandom);
         if (!ready) nlow++;
         if (!serial) slow++;
      end
      send = 1'b0;
      check("empty_ready_low_cycles", nlow, 0);
      check("empty_serial_low_cycles", slow, 0);

      // Busy request is ignored
      @(negedge clk);
      msg_bytes = 24'h12_34_56;
      msg_len = 2'd3;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      repeat (100) @(negedge clk);
      msg_bytes = 24'hFF_FF_00;
      msg_len = 2'd1;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      dcount = 0;
      for (int i = 0; i < 500 && !ready; i++) begin
         @(negedge clk);
         if (tx_done) dcount++;
      end
      check("busy_done_pulses", dcount, 1);
      repeat (20) @(negedge clk);
      check("busy_not_queued_ready", int'(ready), 1);

      // Reset during data bit 3 of byte 1
      @(negedge clk);
      msg_bytes = 24'h40_3C_90;
      msg_len = 2'd3;
      send = 1'b1;
      @(posedge clk);
      #1 send = 1'b0;
      repeat (14 * C + 6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_serial", int'(serial), 1);
      check("abort_ready", int'(ready), 1);
      check("abort_tx_done", int'(tx_done), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send_observe(24'h7F_40_B0, 2'd3, bits, low, dcount, dat);
      check_frames("after_abort_frame", bits, 3, 24'h7F_40_B0);
      check("after_abort_done_at", dat, 480);

      // Random traffic: requests of any length at any time, checked by the model every cycle
      for (int i = 0; i < 15000; i++) begin
         @(negedge clk);
         msg_bytes = 24'($urandom);
         msg_len = 2'($urandom);
         send = ($urandom_range(0, 7) == 0);
      end
      send = 1'b0;
      wait_ready(600);
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/midi_out.md
# midi_out

MIDI serial transmitter: accepts a 1- to 3-byte MIDI message on a valid/ready handshake and shifts it out as standard 8-N-1 asynchronous frames at 31250 baud. It is the transmit counterpart of the MIDI input receiver and feeds the MIDI OUT/THRU line driver.

- Byte packing matches the receiver's `out_bytes` layout, so a received word can be looped straight back out.

## Interface

- `CLKS_PER_BIT`, default 1600: clock cycles per serial bit (50 MHz / 31250 baud). Legal range ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `msg_bytes`  in  24  message to send; byte 0 = [7:0] (status), byte 1 = [15:8], byte 2 = [23:16].
- `msg_len`  in  2  number of bytes to send, 1..3; 0 = empty message.
- `send`  in  1  request valid.
- `ready`  out  1  transmitter idle; can accept a request this cycle.
- `serial`  out  1  MIDI TX line; idle high.
- `tx_done`  out  1  one-cycle pulse when the last stop bit of a message completes.

## Operation

- **Handshake:** a request is accepted at a rising edge where `send && ready`.
  - `msg_bytes` and `msg_len` are captured into internal registers on that edge.
  - Inputs are don't-care at all other times.
- **Empty message:** `msg_len == 0` is accepted and discarded. `ready` stays 1, `serial` stays 1, and `tx_done` is not pulsed.
- **States:** IDLE, START, DATA, STOP.
  - IDLE → START on acceptance (`msg_len != 0`).
  - START → DATA after one bit time.
  - DATA → STOP after 8 bit times.
  - STOP → START if bytes remain; otherwise STOP → IDLE.
- **Frame per byte:** start bit 0, then data bits LSB first (bit 0 .. bit 7), then one stop bit 1.
- **Byte order:** byte 0, then byte 1, then byte 2, up to `msg_len` bytes.
- **No gaps within a message:** consecutive bytes of one message are sent back-to-back, with no idle time between a stop bit and the next start bit.
- **Counters:**
  - Bit-time counter: 0..`CLKS_PER_BIT`-1, wraps at the end of each bit.
  - Bit index: 0..7.
  - Byte index: 0..2, compared against the captured length.
- **Registered outputs:** `serial`, `ready` and `tx_done` are all registered, with no combinational path from the inputs.
- **Reset values** (asynchronous, immediate): `serial`=1, `ready`=1, `tx_done`=0, state IDLE, all counters 0. Reset mid-frame aborts the message with no completion pulse; the line returns high at once.

## Timing

- Let E0 be the accepting edge, C = `CLKS_PER_BIT`, and N = `msg_len`.
- **At E0:** `ready` goes to 0 and `serial` goes to 0 (start bit of byte 0) in the same edge. Latency from acceptance to line activity is 0 cycles.
- **Bit placement:** frame bit k of byte j (k = 0 start, 1..8 data, 9 stop) is driven from edge E0+(10j+k)·C up to, but not including, edge E0+(10j+k+1)·C.
- **At edge E0+10·N·C:**
  - `ready` goes to 1.
  - `tx_done` goes to 1 for exactly one cycle.
  - `serial` stays 1.
- **Minimum idle between messages:** `ready` is registered, so the earliest next acceptance is edge E0+10·N·C+1. This gives a minimum idle of one clock between messages.
- **`send` while busy:** ignored and not queued. The requester must hold `send` until it sees `ready`.
- **Message duration:** 1 byte = 10·C cycles; 3 bytes = 30·C cycles (48000 cycles at the default C).

## Test plan

- **Reset state:** C=1600; hold `rst`, then release → `serial`=1, `ready`=1, `tx_done`=0; no activity for 10000 cycles with `send`=0.
- **Note On, 3 bytes:** C=16; send `msg_bytes`=24'h40_3C_90, `msg_len`=3 → line carries frames for 0x90, 0x3C, 0x40, LSB first, each bit exactly 16 cycles. `ready` is low for exactly 480 cycles, and `tx_done` pulses once at E0+480.
- **Two-byte message, back-to-back:** C=16; send `msg_bytes`=24'h00_05_C0, `msg_len`=2, with `send` held high → second acceptance occurs at E0+321. Line is idle high for exactly 1 cycle between messages.
- **Empty and busy requests:** `msg_len`=0 → no line activity, `ready` never drops. Pulse `send` with new data mid-message → current message unchanged and the new data is never sent.
- **Reset mid-frame:** assert `rst` during data bit 3 of byte 1 → `serial`=1 and `ready`=1 immediately (asynchronous), no `tx_done` pulse. A subsequent request transmits correctly from byte 0.
- **Loopback:** loop `serial` into the MIDI receiver at C=1600; send 24'h7F_40_B0 → receiver `out_bytes`=24'h7F_40_B0.
